// File: rtl/i2c_eeprom_pkg.sv
// Shared definitions for the I2C EEPROM controller.
//   state_e     : controller FSM states
//   req_t       : request captured on the accepting cycle
//   DEV_PREFIX  : EEPROM device-type nibble of the control byte
//   CLK_DIV_DEF : default clk cycles per SCL quarter-period
//   WR_BITS / RD_BITS : bit periods of a write / read transaction
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_CTRL, ST_ADDR, ST_WDATA,
    ST_RSTART, ST_CTRLR, ST_RDATA, ST_STOP
  } state_e;

  typedef struct packed {
    logic        rd;
    logic [10:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam logic [3:0] DEV_PREFIX  = 4'b1010;
  localparam int         CLK_DIV_DEF = 25;
  localparam int         WR_BITS     = 29;
  localparam int         RD_BITS     = 39;

  // Control byte: device prefix, page bits, R/W flag.
  function automatic logic [7:0] ctrl_byte(input logic [2:0] page, input logic rd);
    return {DEV_PREFIX, page, rd};
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-phase generator for the I2C bit period.
//   clk, rst_n : system clock, async active-low reset
//   en         : run; when low the phase is held at q0, count 0
//   tick       : last clk of the current quarter
//   q_first    : first clk of the current quarter
//   q          : quarter index q0..q3 within the bit period
module i2c_clk_div
  import i2c_eeprom_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output logic       q_first,
  output logic [1:0] q
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick    = (cnt == CW'(CLK_DIV - 1));
  assign q_first = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 2'd0;
    end else if (!en) begin
      cnt <= '0;
      q   <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_eeprom_ctrl.sv
// Single-byte random read/write controller for an I2C EEPROM.
//   clk, rst_n     : system clock, async active-low reset
//   wr_req, rd_req : one-cycle request pulses (write wins on collision)
//   addr, wdata    : 11-bit byte address ([10:8] page), write data
//   rdata          : last read byte, held until the next read completes
//   busy, done     : transaction in flight / one-cycle completion pulse
//   ack_err        : sticky missing-ACK flag, cleared on accept
//   scl, sda       : I2C bus; sda is open-drain (driven low or released)
module i2c_eeprom_ctrl
  import i2c_eeprom_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  state_e      state, state_nxt;
  req_t        req_q;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  tx_byte;
  logic        sda_low;
  logic        tick, q_first;
  logic [1:0]  q;

  logic accept, bit_end, sample, last_bit, tx_state;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != ST_IDLE),
    .tick    (tick),
    .q_first (q_first),
    .q       (q)
  );

  assign accept   = (state == ST_IDLE) && (wr_req || rd_req);
  assign bit_end  = tick && (q == 2'd3);
  assign sample   = q_first && (q == 2'd2);
  assign last_bit = (bit_cnt == 4'd8);
  assign tx_state = (state == ST_CTRL) || (state == ST_ADDR) ||
                    (state == ST_WDATA) || (state == ST_CTRLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (wr_req || rd_req)     state_nxt = ST_START;
      ST_START:  if (bit_end)              state_nxt = ST_CTRL;
      ST_CTRL:   if (bit_end && last_bit)  state_nxt = ST_ADDR;
      ST_ADDR:   if (bit_end && last_bit)  state_nxt = req_q.rd ? ST_RSTART : ST_WDATA;
      ST_WDATA:  if (bit_end && last_bit)  state_nxt = ST_STOP;
      ST_RSTART: if (bit_end)              state_nxt = ST_CTRLR;
      ST_CTRLR:  if (bit_end && last_bit)  state_nxt = ST_RDATA;
      ST_RDATA:  if (bit_end && last_bit)  state_nxt = ST_STOP;
      ST_STOP:   if (bit_end)              state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // Bus waveform per state and quarter. Data bits toggle scl high in q1/q2;
  // START/STOP move sda while scl is high at q2 entry.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    tx_byte = 8'h00;
    case (state)
      ST_CTRL:  tx_byte = ctrl_byte(req_q.addr[10:8], 1'b0);
      ST_ADDR:  tx_byte = req_q.addr[7:0];
      ST_WDATA: tx_byte = req_q.wdata;
      ST_CTRLR: tx_byte = ctrl_byte(req_q.addr[10:8], 1'b1);
      default:  tx_byte = 8'h00;
    endcase
    case (state)
      ST_IDLE: ;
      ST_START, ST_RSTART: begin
        scl     = q[0] ^ q[1];
        sda_low = q[1];
      end
      ST_STOP: begin
        scl     = (q != 2'd0);
        sda_low = !q[1];
      end
      ST_RDATA: scl = q[0] ^ q[1];
      default: begin
        scl     = q[0] ^ q[1];
        sda_low = !last_bit && !tx_byte[3'd7 - bit_cnt[2:0]];
      end
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      bit_cnt <= 4'd0;
      rx_sh   <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        req_q   <= '{rd: !wr_req, addr: addr, wdata: wdata};
        busy    <= 1'b1;
        ack_err <= 1'b0;
      end
      // Single-bit states always change on bit_end, byte states only after
      // the ACK slot, so a state change is the natural counter restart.
      if (bit_end)
        bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
      if (sample) begin
        if (tx_state && last_bit && sda) ack_err <= 1'b1;
        if (state == ST_RDATA && !last_bit) rx_sh <= {rx_sh[6:0], sda};
      end
      if (state == ST_STOP && bit_end) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (req_q.rd) rdata <= rx_sh;
      end
    end
  end

endmodule

// File: doc/i2c_eeprom_ctrl.md
I2C_EEPROM_CTRL -- requirements
Module: i2c_eeprom_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per SCL quarter-period; one SCL period is 4*CLK_DIV clk cycles.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 wr_req  input  1  one-cycle pulse; starts a single-byte random write.
REQ-005 rd_req  input  1  one-cycle pulse; starts a single-byte random read.
REQ-006 addr  input  11  EEPROM byte address; [10:8] are the page bits, [7:0] the word address.
REQ-007 wdata  input  8  write data.
REQ-008 rdata  output  8  read data, held until the next read completes.
REQ-009 busy  output  1  high from the cycle after an accepted request until done.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 ack_err  output  1  sticky; set when any ACK slot samples SDA high; cleared on the next accepted request.
REQ-012 scl  output  1  I2C clock, push-pull.
REQ-013 sda  inout  1  I2C data; driven low or released (Z) only; released means 1 via pull-up.

Function
REQ-014 Bit period timing: 4 quarters q0..q3 per bit, each CLK_DIV clk cycles long.
- scl is 0 in q0/q3 and 1 in q1/q2.
- sda changes only at q0 entry.
- Slave data is sampled on the first clk of q2.
REQ-015 Bus sequences:
- START: 1 bit period; sda 1->0 while scl=1, then scl falls.
- STOP: 1 bit period; sda 0->1 while scl=1.
- Repeated START (RSTART): same as START, preceded by sda released during scl low.
REQ-016 Byte format: MSB first, 8 bits, then a 9th ACK slot.
- Master releases sda for ACK on write bytes.
- Master drives NACK (released) after read data.
REQ-017 Control bytes:
- CTRL_W = {4'b1010, addr[10:8], 1'b0}.
- CTRL_R = {4'b1010, addr[10:8], 1'b1}.
REQ-018 FSM states: IDLE, START, CTRL, ADDR, WDATA, RSTART, CTRLR, RDATA, STOP.
REQ-019 Write path: IDLE -> START -> CTRL(CTRL_W) -> ADDR(addr[7:0]) -> WDATA(wdata) -> STOP -> IDLE; total 29 bit periods.
REQ-020 Read path: IDLE -> START -> CTRL(CTRL_W) -> ADDR -> RSTART -> CTRLR(CTRL_R) -> RDATA(8 bits + NACK) -> STOP -> IDLE; total 39 bit periods.
REQ-021 addr and wdata are latched on the accepting cycle; later input changes have no effect on an in-flight transaction.
REQ-022 rdata updates on the cycle STOP completes, the same cycle done pulses.
REQ-023 done pulses exactly once per transaction; busy falls in the same cycle.
REQ-024 A NACK does not abort the transaction: the sequence completes and ack_err is set.
REQ-025 wr_req and rd_req asserted in the same IDLE cycle: the write is performed and the read is dropped.
REQ-026 Requests while busy=1 are ignored, not queued.
REQ-027 IDLE bus state: scl=1, sda released.

Reset
REQ-028 rst_n low at any time (including mid-transaction) immediately, without waiting for clk, forces:
- state IDLE, scl=1, sda released;
- busy=0, done=0, ack_err=0, rdata=8'h00;
- all counters to 0.
REQ-029 After rst_n deasserts, the first request is accepted no earlier than the next rising clk edge.

Structure
REQ-030 Shared package i2c_eeprom_pkg holds:
- FSM state enum;
- device prefix 4'b1010;
- CLK_DIV default;
- bit-period counts (29 for write, 39 for read).
REQ-031 One sub-module, i2c_clk_div, generates the quarter-phase tick and the q0..q3 index; the FSM is the only consumer.

Verification (bench uses the team EEPROM slave model on the bus, with a pull-up on sda; CLK_DIV=4)
REQ-032 Write: wr_req with addr=11'h3C7, wdata=8'h5A.
- Bus bytes: 0xA6, 0xC7, 0x5A, then STOP.
- Model memory[0x3C7]=0x5A.
- done after 29*16 clks.
REQ-033 Read-back: rd_req with addr=11'h3C7.
- Bus: 0xA6, 0xC7, RSTART, 0xA7.
- rdata=8'h5A when done pulses, 39*16 clks after acceptance.
REQ-034 Boundary address: write with addr=11'h7FF, wdata=8'hFF.
- Control byte 0xAE, address byte 0xFF.
- Read-back returns 8'hFF.
REQ-035 Collisions: wr_req and rd_req asserted in the same cycle.
- Only the write sequence appears on the bus.
- A second rd_req pulsed mid-write produces no extra transaction and no second done.
REQ-036 Reset mid-operation: assert rst_n during the ADDR byte of a write.
- scl=1 and sda=Z immediately.
- The model sees a STOP and its memory is unchanged.
- A subsequent write completes normally.
REQ-037 No-ACK slave: bench never drives ACK.
- ack_err=1 at done and the transaction length is unchanged.
- ack_err clears on the next accepted request.
